// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU select codes and state encoding for the hardwired control unit.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier feeding the control sequencer.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] alu_select,
  output logic       is_imm,
  output logic       is_hilo,
  output logic       is_unary,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    alu_select = ALU_ADD;
    is_imm     = 1'b0;
    is_hilo    = 1'b0;
    is_unary   = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD:  alu_select = ALU_ADD;
      OP_SUB:  alu_select = ALU_SUB;
      OP_SHR:  alu_select = ALU_SHR;
      OP_SHL:  alu_select = ALU_SHL;
      OP_ROR:  alu_select = ALU_ROR;
      OP_ROL:  alu_select = ALU_ROL;
      OP_AND:  alu_select = ALU_AND;
      OP_OR:   alu_select = ALU_OR;
      OP_ADDI: begin alu_select = ALU_ADD; is_imm = 1'b1; end
      OP_ANDI: begin alu_select = ALU_AND; is_imm = 1'b1; end
      OP_ORI:  begin alu_select = ALU_OR;  is_imm = 1'b1; end
      OP_MUL:  begin alu_select = ALU_MUL; is_hilo = 1'b1; end
      OP_DIV:  begin alu_select = ALU_DIV; is_hilo = 1'b1; end
      OP_NEG:  begin alu_select = ALU_NEG; is_unary = 1'b1; end
      OP_NOT:  begin alu_select = ALU_NOT; is_unary = 1'b1; end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Hardwired Moore sequencer for the 16-register bus datapath: fetch T0-T2, execute T3-T6.
// Optional MEM_WAIT_EN stretches T1 until mem_ready.
module datapath_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [15:0]      reg_in,
  output logic [15:0]      reg_out,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             ZIn,
  output logic             ZLowout,
  output logic             ZHighout,
  output logic             HIin,
  output logic             LOin,
  output logic             Cout,
  output logic [3:0]       alu_select,
  output logic             running,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] ra, rb, rc, dec_alu;
  logic       is_imm, is_hilo, is_unary, is_nop, is_halt, is_illegal;
  logic       halt_req;
  logic [14:0] unused_imm;

  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_imm = ir[14:0];

  ctrl_decode u_dec (
    .opcode    (ir[31:27]),
    .alu_select(dec_alu),
    .is_imm    (is_imm),
    .is_hilo   (is_hilo),
    .is_unary  (is_unary),
    .is_nop    (is_nop),
    .is_halt   (is_halt),
    .is_illegal(is_illegal)
  );

`ifndef MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  // A stop seen at any point of the instruction is remembered so it takes
  // effect at the boundary even if the level has dropped by then.
  assign halt_req = stop | stop_pend_q;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q | stop;
    case (state_q)
      S_IDLE, S_HALT: begin
        stop_pend_d = start & stop;
        if (start) state_d = S_T0;
      end
      S_T0: state_d = S_T1;
`ifdef MEM_WAIT_EN
      S_T1: if (mem_ready) state_d = S_T2;
`else
      S_T1: state_d = S_T2;
`endif
      S_T2: begin
        if (is_illegal) begin
          state_d     = S_HALT;
          illegal_d   = 1'b1;
          stop_pend_d = 1'b0;
        end else if (is_halt || is_nop) begin
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = (is_halt || halt_req) ? S_HALT : S_T0;
          stop_pend_d = 1'b0;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5, S_T6: begin
        if (state_q == S_T5 && is_hilo) begin
          state_d = S_T6;
        end else begin
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = halt_req ? S_HALT : S_T0;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      illegal_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    reg_in     = '0;
    reg_out    = '0;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    Read       = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZIn        = 1'b0;
    ZLowout    = 1'b0;
    ZHighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Cout       = 1'b0;
    alu_select = '0;
    running    = 1'b1;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
`ifdef MEM_WAIT_EN
        PCin    = mem_ready;
        ZLowout = mem_ready;
`else
        PCin    = 1'b1;
        ZLowout = 1'b1;
`endif
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin reg_out[rb] = 1'b1; Yin = 1'b1; end
      S_T4: begin
        if (is_imm)        Cout = 1'b1;
        else if (is_unary) reg_out[rb] = 1'b1;
        else               reg_out[rc] = 1'b1;
        alu_select = dec_alu;
        ZIn        = 1'b1;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (is_hilo) LOin = 1'b1;
        else         reg_in[ra] = 1'b1;
      end
      S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
      default: running = 1'b0;
    endcase
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Randomized bench for datapath_control_unit against an instruction-level model.
module tb_datapath_control_unit;
  localparam int CNT_W = 16;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] reg_in, reg_out;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZIn;
  logic ZLowout, ZHighout, HIin, LOin, Cout, running, illegal;
  logic [3:0] alu_select;
  logic [CNT_W-1:0] instr_count;

  datapath_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .ir(ir), .mem_ready(mem_ready),
    .reg_in(reg_in), .reg_out(reg_out), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin),
    .ZIn(ZIn), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
    .alu_select(alu_select), .running(running), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // strobe bit positions
  localparam int B_PCOUT = 14, B_PCIN = 13, B_INCPC = 12, B_MARIN = 11, B_MDRIN = 10;
  localparam int B_MDROUT = 9, B_READ = 8, B_IRIN = 7, B_YIN = 6, B_ZIN = 5;
  localparam int B_ZLOW = 4, B_ZHIGH = 3, B_HIIN = 2, B_LOIN = 1, B_COUT = 0;

  wire [14:0] strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZIn,
                      ZLowout, ZHighout, HIin, LOin, Cout};

  int checks = 0, failures = 0;
  logic chk_en = 1'b0;
  logic [15:0] e_reg_in, e_reg_out;
  logic [14:0] e_strb;
  logic [3:0] e_alu;
  logic e_run, e_ill;
  logic [CNT_W-1:0] e_cnt;
  logic [CNT_W-1:0] m_count;
  logic m_ill;

  logic [15:0] cap_reg_in [0:6];
  logic [15:0] cap_reg_out[0:6];
  logic [14:0] cap_strb   [0:6];
  logic [3:0]  cap_alu    [0:6];
  int last_lat, t1_read, t1_pcin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // instruction classes: 0 illegal, 1 reg-reg, 2 immediate, 3 unary, 4 mul/div, 5 nop, 6 halt
  function automatic int cls(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return 1;
      5'd11, 5'd12, 5'd13: return 2;
      5'd17, 5'd18: return 3;
      5'd15, 5'd16: return 4;
      5'd26: return 5;
      5'd27: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd11: return 4'd0;
      5'd4:        return 4'd1;
      5'd9, 5'd12: return 4'd2;
      5'd10, 5'd13: return 4'd3;
      5'd5: return 4'd4;
      5'd6: return 4'd5;
      5'd7: return 4'd6;
      5'd8: return 4'd7;
      5'd15: return 4'd8;
      5'd16: return 4'd9;
      5'd17: return 4'd10;
      5'd18: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] rc, input logic [14:0] lo);
    return {op, ra, rb, rc, lo};
  endfunction

  // Expected outputs for one cycle; ph = -1 means idle/halted, 0..6 = T-state.
  task automatic set_exp(input int ph, input logic [31:0] irv, input logic rdy);
    int c;
    c = cls(irv[31:27]);
    e_reg_in = '0; e_reg_out = '0; e_strb = '0; e_alu = '0;
    e_run = (ph >= 0); e_ill = m_ill; e_cnt = m_count;
    case (ph)
      0: begin e_strb[B_PCOUT] = 1; e_strb[B_MARIN] = 1; e_strb[B_INCPC] = 1; e_strb[B_ZIN] = 1; end
      1: begin
        e_strb[B_READ] = 1; e_strb[B_MDRIN] = 1;
        e_strb[B_PCIN] = rdy; e_strb[B_ZLOW] = rdy;
      end
      2: begin e_strb[B_MDROUT] = 1; e_strb[B_IRIN] = 1; end
      3: begin e_reg_out = 16'h1 << irv[22:19]; e_strb[B_YIN] = 1; end
      4: begin
        if (c == 2) e_strb[B_COUT] = 1;
        else e_reg_out = 16'h1 << ((c == 3) ? irv[22:19] : irv[18:15]);
        e_alu = alu_of(irv[31:27]);
        e_strb[B_ZIN] = 1;
      end
      5: begin
        e_strb[B_ZLOW] = 1;
        if (c == 4) e_strb[B_LOIN] = 1;
        else e_reg_in = 16'h1 << irv[26:23];
      end
      6: begin e_strb[B_ZHIGH] = 1; e_strb[B_HIIN] = 1; end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_in", 32'(reg_in), 32'(e_reg_in));
      chk("reg_out", 32'(reg_out), 32'(e_reg_out));
      chk("strobes", 32'(strb), 32'(e_strb));
      chk("alu_select", 32'(alu_select), 32'(e_alu));
      chk("running", 32'(running), 32'(e_run));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("instr_count", 32'(instr_count), 32'(e_cnt));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic capture(input int ph);
    #1;
    cap_reg_in[ph] = reg_in; cap_reg_out[ph] = reg_out; cap_strb[ph] = strb; cap_alu[ph] = alu_select;
    if (ph == 1) begin t1_read += int'(Read); t1_pcin += int'(PCin); end
  endtask

  // Drives one instruction from T0; on entry the DUT is expected to be in T0.
  task automatic run_instr(input logic [31:0] irv, input int stop_from, input int waits,
                           input int rst_at, input bit pend, output bit halted);
    int c, ph_last, lat, sf;
    c = cls(irv[31:27]);
    ph_last = (c == 0 || c == 5 || c == 6) ? 2 : ((c == 4) ? 6 : 5);
    sf = (stop_from > ph_last) ? ph_last : stop_from;
    lat = 0; t1_read = 0; t1_pcin = 0; halted = 0;
    ir = irv;
    for (int ph = 0; ph <= ph_last; ph++) begin
      stop = (sf >= 0 && ph >= sf);
      if (ph == 1) begin
`ifdef MEM_WAIT_EN
        for (int w = 0; w < waits; w++) begin
          mem_ready = 1'b0; set_exp(1, irv, 1'b0); capture(1); lat++; tick();
        end
        mem_ready = 1'b1;
`else
        mem_ready = (waits > 0) ? 1'b0 : 1'($urandom_range(1, 0));
`endif
      end
      set_exp(ph, irv, 1'b1);
      if (ph == rst_at) reset_n = 1'b0;
      capture(ph); lat++; tick();
      if (ph == rst_at) begin
        reset_n = 1'b1; stop = 1'b0; m_count = '0; m_ill = 1'b0;
        halted = 1; last_lat = lat; set_exp(-1, irv, 1'b1);
        return;
      end
    end
    stop = 1'b0;
    if (c == 0) begin
      m_ill = 1'b1; halted = 1;
    end else begin
      m_count = m_count + 1'b1;
      halted = (c == 6) || (sf >= 0) || pend;
    end
    last_lat = lat;
    set_exp(halted ? -1 : 0, irv, 1'b1);
  endtask

  task automatic resume(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    set_exp(0, ir, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [31:0] irv;
    logic [4:0] op;
    int c, sf, ra_ph;
    logic [4:0] legal [0:16];
    legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
              5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
    m_count = '0; m_ill = 1'b0;
    reset_n = 1'b0;
    tick();
    set_exp(-1, 32'h0, 1'b1);
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_count", 32'(instr_count), 32'h0);

    // and R5,R2,R4
    start = 1'b1; tick(); start = 1'b0;
    run_instr(32'h4A920000, -1, 0, -1, 0, h);
    chk("and_t0", 32'(cap_strb[0]), 32'h5820);
    chk("and_t3_reg_out", 32'(cap_reg_out[3]), 32'h0004);
    chk("and_t4_reg_out", 32'(cap_reg_out[4]), 32'h0010);
    chk("and_t4_alu", 32'(cap_alu[4]), 32'h2);
    chk("and_t5_reg_in", 32'(cap_reg_in[5]), 32'h0020);
    chk("and_latency", 32'(last_lat), 32'd6);
    chk("and_count", 32'(instr_count), 32'd1);

    // mul R0,R3,R6
    run_instr(32'h781B0000, -1, 0, -1, 0, h);
    chk("mul_t5_loin", 32'(cap_strb[5][B_LOIN]), 32'h1);
    chk("mul_t5_reg_in", 32'(cap_reg_in[5]), 32'h0);
    chk("mul_t6_hi", 32'(cap_strb[6]), 32'h000C);
    chk("mul_latency", 32'(last_lat), 32'd7);

    // addi R5,R2,5
    run_instr(32'h5A900005, -1, 0, -1, 0, h);
    chk("addi_t4_cout", 32'(cap_strb[4][B_COUT]), 32'h1);
    chk("addi_t4_reg_out", 32'(cap_reg_out[4]), 32'h0);
    chk("addi_t4_alu", 32'(cap_alu[4]), 32'h0);

    run_instr(mk(5'd26, 4'd0, 4'd0, 4'd0, 15'd0), -1, 0, -1, 0, h);
    chk("nop_latency", 32'(last_lat), 32'd3);
    chk("nop_count", 32'(instr_count), 32'd4);

    // stop raised in T3 of an and: instruction completes then halts
    run_instr(32'h4A920000, 3, 0, -1, 0, h);
    chk("stop_t5_reg_in", 32'(cap_reg_in[5]), 32'h0020);
    chk("stop_halted", 32'(running), 32'h0);
    chk("stop_count", 32'(instr_count), 32'd5);
    resume(2);

    // undefined opcode
    run_instr(mk(5'd31, 4'd1, 4'd2, 4'd3, 15'd0), -1, 0, -1, 0, h);
    chk("illegal_flag", 32'(illegal), 32'h1);
    chk("illegal_running", 32'(running), 32'h0);
    chk("illegal_count", 32'(instr_count), 32'd5);
    resume(1);
    chk("illegal_resume_running", 32'(running), 32'h1);
    chk("illegal_resume_sticky", 32'(illegal), 32'h1);

    // reset during T4
    run_instr(32'h4A920000, -1, 0, 4, 0, h);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_strobes", 32'(strb), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);

    // start and stop together from IDLE: one instruction then halt
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    run_instr(mk(5'd3, 4'd1, 4'd2, 4'd3, 15'd0), -1, 0, -1, 1, h);
    chk("startstop_running", 32'(running), 32'h0);
    chk("startstop_count", 32'(instr_count), 32'd1);

`ifdef MEM_WAIT_EN
    resume(0);
    run_instr(32'h4A920000, -1, 3, -1, 0, h);
    chk("wait_read_cycles", 32'(t1_read), 32'd4);
    chk("wait_pcin_pulses", 32'(t1_pcin), 32'd1);
    chk("wait_latency", 32'(last_lat), 32'd9);
`endif

    resume(0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7, 0) == 0) op = 5'($urandom_range(31, 0));
      else op = legal[$urandom_range(16, 0)];
      irv = mk(op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom));
      c = cls(op);
      sf = ($urandom_range(5, 0) == 0) ? $urandom_range(6, 0) : -1;
      ra_ph = ($urandom_range(39, 0) == 0) ? $urandom_range(2, 0) : -1;
      run_instr(irv, sf, $urandom_range(2, 0), ra_ph, 0, h);
      if (h) resume($urandom_range(2, 0));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
